// File: rtl/control_sequencer.sv
// Hardwired control unit for the RISC datapath: steps fetch/decode/execute
// phases and decodes every datapath enable from (step, opcode, CON).
module control_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Read,
    output logic        Write,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Cout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        CONin,
    output logic        InPortout,
    output logic        OutPortin,
    output logic [4:0]  alu_op,
    output logic        run
);

    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    step_t      step;
    step_t      last_step;
    logic [4:0] opcode;
    logic [4:0] imm_alu;
    logic       unused_ir_fields;

    assign opcode           = IR[31:27];
    assign unused_ir_fields = ^IR[26:0];

    always_comb begin
        last_step = T3;
        imm_alu   = OP_ADD;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_step = T5;
            OP_MUL, OP_DIV, OP_BR:            last_step = T6;
            OP_NEG, OP_NOT:                   last_step = T4;
            OP_LD, OP_ST:                     last_step = T7;
            default:                          last_step = T3;
        endcase
        case (opcode)
            OP_ANDI: imm_alu = OP_AND;
            OP_ORI:  imm_alu = OP_OR;
            default: imm_alu = OP_ADD;
        endcase
    end

    // ">=" rather than "==" keeps the sequencer inside T0-T7 even if IR
    // changes mid-instruction and shortens the expected sequence.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step <= RST;
        end else begin
            case (step)
                RST:     step <= T0;
                HALT:    step <= HALT;
                default: begin
                    if (step >= last_step && step != T0 && step != T1 && step != T2)
                        step <= (stop || opcode == OP_HALT) ? HALT : T0;
                    else
                        step <= step_t'(step + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout}                       = '0;
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin}        = '0;
        {Read, Write}                                           = '0;
        {Yin, Zin, Zhighout, Zlowout, Cout}                     = '0;
        {HIin, HIout, LOin, LOout, CONin}                       = '0;
        {InPortout, OutPortin}                                  = '0;
        alu_op = 5'b00000;
        run    = (step != HALT);
        case (step)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            T1: begin Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_MUL, OP_DIV:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_NEG, OP_NOT:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                        begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    OP_ADDI, OP_ANDI, OP_ORI:
                        begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu; end
                    OP_MUL, OP_DIV:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    OP_NEG, OP_NOT:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                    OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                        begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MUL, OP_DIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    OP_LD, OP_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
                    OP_BR:   begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                    default: ;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    OP_LD:   begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OP_BR:   begin Zlowout = CON; PCin = CON; end
                    default: ;
                endcase
            end
            T7: begin
                case (opcode)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instructions step by step and
// compares every enable, alu_op and run against hand-derived values.
module tb_control_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] IR;
    logic        CON;
    logic        stop;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic Read, Write;
    logic Yin, Zin, Zhighout, Zlowout, Cout, HIin, HIout, LOin, LOout, CONin;
    logic InPortout, OutPortin;
    logic [4:0] alu_op;
    logic       run;
    logic [26:0] en;

    int checks = 0;
    int failures = 0;

    localparam logic [26:0] E_GRA = 27'd1 << 26, E_GRB = 27'd1 << 25, E_GRC = 27'd1 << 24;
    localparam logic [26:0] E_RIN = 27'd1 << 23, E_ROUT = 27'd1 << 22, E_BAOUT = 27'd1 << 21;
    localparam logic [26:0] E_PCOUT = 27'd1 << 20, E_PCIN = 27'd1 << 19, E_INCPC = 27'd1 << 18;
    localparam logic [26:0] E_MARIN = 27'd1 << 17, E_MDRIN = 27'd1 << 16, E_MDROUT = 27'd1 << 15;
    localparam logic [26:0] E_IRIN = 27'd1 << 14, E_READ = 27'd1 << 13, E_WRITE = 27'd1 << 12;
    localparam logic [26:0] E_YIN = 27'd1 << 11, E_ZIN = 27'd1 << 10, E_ZHIGH = 27'd1 << 9;
    localparam logic [26:0] E_ZLOW = 27'd1 << 8, E_COUT = 27'd1 << 7, E_HIIN = 27'd1 << 6;
    localparam logic [26:0] E_HIOUT = 27'd1 << 5, E_LOIN = 27'd1 << 4, E_LOOUT = 27'd1 << 3;
    localparam logic [26:0] E_CONIN = 27'd1 << 2, E_INPORT = 27'd1 << 1, E_OUTPORT = 27'd1 << 0;
    localparam logic [26:0] E_NONE = 27'd0;

    control_sequencer dut (
        .clock(clock), .reset_n(reset_n), .IR(IR), .CON(CON), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Read(Read), .Write(Write),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .CONin(CONin),
        .InPortout(InPortout), .OutPortin(OutPortin), .alu_op(alu_op), .run(run)
    );

    assign en = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                 MDRout, IRin, Read, Write, Yin, Zin, Zhighout, Zlowout, Cout,
                 HIin, HIout, LOin, LOout, CONin, InPortout, OutPortin};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Outputs are combinational from the step register, so sampling at the
    // falling edge sees the settled decode of the step entered on the rising edge.
    task automatic sampleNow(input string tag, input logic [26:0] en_exp,
                             input logic [4:0] alu_exp, input logic run_exp);
        checkOutput({tag, " en"},  {5'd0, en},     {5'd0, en_exp});
        checkOutput({tag, " alu"}, {27'd0, alu_op}, {27'd0, alu_exp});
        checkOutput({tag, " run"}, {31'd0, run},    {31'd0, run_exp});
    endtask

    task automatic stepCheck(input string tag, input logic [26:0] en_exp,
                             input logic [4:0] alu_exp);
        @(negedge clock);
        sampleNow(tag, en_exp, alu_exp, 1'b1);
    endtask

    // IR/CON are loaded during T0 so they are stable well before T3.
    task automatic applyStimulus(input string tag, input logic [4:0] op, input logic con);
        @(negedge clock);
        sampleNow({tag, " T0"}, E_PCOUT | E_MARIN | E_INCPC, 5'd0, 1'b1);
        IR  = {op, 27'h2AAAAAA};
        CON = con;
        stepCheck({tag, " T1"}, E_READ | E_MDRIN, 5'd0);
        stepCheck({tag, " T2"}, E_MDROUT | E_IRIN, 5'd0);
    endtask

    task automatic ldStStart(input string tag);
        stepCheck({tag, " T3"}, E_GRB | E_BAOUT | E_YIN, 5'd0);
        stepCheck({tag, " T4"}, E_COUT | E_ZIN, 5'b00011);
        stepCheck({tag, " T5"}, E_ZLOW | E_MARIN, 5'd0);
    endtask

    task automatic brBody(input string tag);
        stepCheck({tag, " T3"}, E_GRA | E_ROUT | E_CONIN, 5'd0);
        stepCheck({tag, " T4"}, E_PCOUT | E_YIN, 5'd0);
        stepCheck({tag, " T5"}, E_COUT | E_ZIN, 5'b00011);
    endtask

    initial begin
        reset_n = 1'b0;
        IR      = 32'd0;
        CON     = 1'b0;
        stop    = 1'b0;
        #12;
        sampleNow("reset", E_NONE, 5'd0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        // add, with a stop pulse during T3 that must be ignored
        applyStimulus("add", 5'b00011, 1'b0);
        stepCheck("add T3", E_GRB | E_ROUT | E_YIN, 5'd0);
        stop = 1'b1;
        stepCheck("add T4", E_GRC | E_ROUT | E_ZIN, 5'b00011);
        stop = 1'b0;
        stepCheck("add T5", E_ZLOW | E_GRA | E_RIN, 5'd0);

        applyStimulus("ld", 5'b00000, 1'b0);
        ldStStart("ld");
        stepCheck("ld T6", E_READ | E_MDRIN, 5'd0);
        stepCheck("ld T7", E_MDROUT | E_GRA | E_RIN, 5'd0);

        applyStimulus("st", 5'b00010, 1'b0);
        ldStStart("st");
        stepCheck("st T6", E_GRA | E_ROUT | E_MDRIN, 5'd0);
        stepCheck("st T7", E_WRITE, 5'd0);

        applyStimulus("br0", 5'b10010, 1'b0);
        brBody("br0");
        stepCheck("br0 T6", E_NONE, 5'd0);

        applyStimulus("br1", 5'b10010, 1'b1);
        brBody("br1");
        stepCheck("br1 T6", E_ZLOW | E_PCIN, 5'd0);

        applyStimulus("mul", 5'b01110, 1'b0);
        stepCheck("mul T3", E_GRA | E_ROUT | E_YIN, 5'd0);
        stepCheck("mul T4", E_GRB | E_ROUT | E_ZIN, 5'b01110);
        stepCheck("mul T5", E_ZLOW | E_LOIN, 5'd0);
        stepCheck("mul T6", E_ZHIGH | E_HIIN, 5'd0);

        applyStimulus("andi", 5'b01100, 1'b0);
        stepCheck("andi T3", E_GRB | E_ROUT | E_YIN, 5'd0);
        stepCheck("andi T4", E_COUT | E_ZIN, 5'b00101);
        stepCheck("andi T5", E_ZLOW | E_GRA | E_RIN, 5'd0);

        applyStimulus("neg", 5'b10000, 1'b0);
        stepCheck("neg T3", E_GRB | E_ROUT | E_ZIN, 5'b10000);
        stepCheck("neg T4", E_ZLOW | E_GRA | E_RIN, 5'd0);

        applyStimulus("in", 5'b10110, 1'b0);
        stepCheck("in T3", E_INPORT | E_GRA | E_RIN, 5'd0);

        applyStimulus("mfhi", 5'b11000, 1'b0);
        stepCheck("mfhi T3", E_HIOUT | E_GRA | E_RIN, 5'd0);

        applyStimulus("undef", 5'b11110, 1'b0);
        stepCheck("undef T3", E_NONE, 5'd0);

        // asynchronous reset during T4 of add
        applyStimulus("addr", 5'b00011, 1'b0);
        stepCheck("addr T3", E_GRB | E_ROUT | E_YIN, 5'd0);
        stepCheck("addr T4", E_GRC | E_ROUT | E_ZIN, 5'b00011);
        reset_n = 1'b0;
        #1;
        sampleNow("async rst", E_NONE, 5'd0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        // stop on the last step of add diverts to HALT
        applyStimulus("adds", 5'b00011, 1'b0);
        stepCheck("adds T3", E_GRB | E_ROUT | E_YIN, 5'd0);
        stepCheck("adds T4", E_GRC | E_ROUT | E_ZIN, 5'b00011);
        stepCheck("adds T5", E_ZLOW | E_GRA | E_RIN, 5'd0);
        stop = 1'b1;
        @(negedge clock);
        sampleNow("stop halt", E_NONE, 5'd0, 1'b0);
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            sampleNow("stop hold", E_NONE, 5'd0, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        sampleNow("halt exit rst", E_NONE, 5'd0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus("halt", 5'b11011, 1'b0);
        stepCheck("halt T3", E_NONE, 5'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            sampleNow("halt hold", E_NONE, 5'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the RISC datapath. Each clock it steps one control phase through fetch, decode and execute. It drives the register-select strobes (Gra/Grb/Grc, Rin, Rout, BAout) consumed by the select/encode logic, plus the bus, ALU, memory and I/O enables. One instruction takes 4 to 8 steps; the unit stops in HALT on the halt opcode or an external stop request.

## Interface
Parameters:
- none

Ports:
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous, active-low reset
- IR  input  32  instruction register contents; opcode = IR[31:27]
- CON  input  1  branch condition flag from the CON FF logic
- stop  input  1  external halt request
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-select strobes
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin  output  1 each  fetch/address path enables
- Read, Write  output  1 each  memory strobes; MDRin with Read=1 loads memory data, otherwise bus data
- Yin, Zin, Zhighout, Zlowout, Cout, HIin, HIout, LOin, LOout, CONin  output  1 each  ALU/special-register enables
- InPortout, OutPortin  output  1 each  I/O port enables
- alu_op  output  5  ALU operation code
- run  output  1  1 while sequencing, 0 in HALT

## Operation
- Step register: RST, T0–T7, HALT. Every output is a combinational decode of (step, IR[31:27], CON). Any output not listed for a step is 0. alu_op = 0 outside the listed steps.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- Execute from T3, by opcode:
  - ALU-reg (00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, alu_op=opcode; T5 Zlowout,Gra,Rin.
  - ALU-imm (01011 addi, 01100 andi, 01101 ori): as ALU-reg, except T4 drives Cout instead of Grc,Rout. alu_op = 00011 / 00101 / 00110 respectively.
  - mul 01110 / div 01111: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin, alu_op=opcode; T5 Zlowout,LOin; T6 Zhighout,HIin.
  - neg 10000 / not 10001: T3 Grb,Rout,Zin, alu_op=opcode; T4 Zlowout,Gra,Rin.
  - ld 00000: T3 Grb,BAout,Yin; T4 Cout,Zin, alu_op=00011; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
  - ldi 00001: T3–T4 as ld; T5 Zlowout,Gra,Rin.
  - st 00010: T3–T5 as ld; T6 Gra,Rout,MDRin; T7 Write.
  - br 10010: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin, alu_op=00011; T6 Zlowout,PCin only if CON=1. At T6 the step always proceeds to T0.
  - jr 10100: T3 Gra,Rout,PCin.
  - in 10110: T3 InPortout,Gra,Rin. out 10111: T3 Gra,Rout,OutPortin.
  - mfhi 11000: T3 HIout,Gra,Rin. mflo 11001: T3 LOout,Gra,Rin.
  - nop 11010, and any undefined opcode: T3 with no enables.
  - halt 11011: T3 with no enables, then HALT.
- The last step of each instruction goes to T0, or to HALT if stop=1 in that cycle. halt always goes to HALT.
- HALT: all enables 0, run=0. Only reset_n exits HALT.

## Timing
- One step per rising clock edge; no wait states. Memory is single-cycle.
- Reset: reset_n=0 forces step=RST immediately (asynchronous), including mid-instruction. The partial instruction is abandoned with no further enables. In RST all enables=0 and run=1. The first edge with reset_n=1 enters T0.
- run=1 in RST and T0–T7.
- Latency: T0 follows the last step. Fetch is 3 cycles. Totals: nop 4, ALU-reg 6, mul/div 7, ld/st 8, br 7 cycles.
- IR is assumed stable from T3 until the instruction ends. CON is sampled combinationally in T6 of br.
- stop is checked only on last steps. A stop pulse that falls before a last step is ignored.

## Test plan
- Reset mid-instruction: assert reset_n=0 during T4 of add -> all enables 0 immediately, run=1. One edge after release: T0 with PCout=MARin=IncPC=1.
- add (opcode 00011): fetch then T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, alu_op=00011; T5 Zlowout,Gra,Rin -> T0 on cycle 7.
- ld vs st: ld asserts Read,MDRin at T6 and MDRout,Gra,Rin at T7. st asserts Gra,Rout,MDRin at T6 and Write at T7. Read=0 in T6 for st.
- br with CON=0 then CON=1: PCin=0 vs PCin=1 (with Zlowout) at T6. Both return to T0 after 7 cycles.
- mul: LOin at T5, HIin at T6, alu_op=01110 at T4.
- halt opcode -> HALT after T3, run=0, enables stay 0 for 20 cycles. Also: stop=1 at T5 of add -> HALT instead of T0.
